// File: rtl/av_config_sequencer.sv
// Walks a table of 16-bit configuration words and writes each one to an I2C
// codec as {DEV_ADDR,W}, byte 1, byte 2, retrying a NACKed word up to MAX_RETRY times.
module av_config_sequencer #(
  parameter int unsigned CLK_DIV   = 250,
  parameter int unsigned NUM_WORDS = 11,
  parameter logic [6:0]  DEV_ADDR  = 7'h1A,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [5:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        i2c_sclk,
  output logic        i2c_sdat_oe,
  input  logic        i2c_sdat_in,
  output logic        busy,
  output logic        done,
  output logic        ack_error
);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, NEXT, DONE} state_t;

  localparam logic [7:0] ADDR_BYTE   = {DEV_ADDR, 1'b0};
  localparam logic [9:0] TICK_LAST   = 10'(CLK_DIV - 1);
  localparam logic [5:0] LAST_ADDR   = 6'(NUM_WORDS - 1);
  localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

  state_t     state;
  logic [9:0] tick_cnt;
  logic       counting;
  logic       tick;
  logic [1:0] phase;
  logic [2:0] bit_cnt;
  logic [1:0] byte_idx;
  logic [7:0] shreg;
  logic [7:0] retry_cnt;
  logic       nacked;
  logic [7:0] next_byte;

  // NEXT and DONE keep the divider parked so every START phase is a full tick long.
  assign counting  = busy && (state inside {START, BIT, ACK, STOP});
  assign tick      = counting && (tick_cnt == TICK_LAST);
  assign next_byte = (byte_idx == 2'd0) ? rom_data[15:8] : rom_data[7:0];

  // Bus levels are registered on the tick that enters each phase, so the pins
  // show the new phase exactly when the FSM does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      phase       <= '0;
      bit_cnt     <= '0;
      byte_idx    <= '0;
      shreg       <= '0;
      retry_cnt   <= '0;
      nacked      <= 1'b0;
      rom_addr    <= '0;
      i2c_sclk    <= 1'b1;
      i2c_sdat_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_error   <= 1'b0;
    end else begin
      tick_cnt <= (!counting || tick) ? '0 : tick_cnt + 10'd1;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          i2c_sclk    <= 1'b1;
          i2c_sdat_oe <= 1'b0;
          if (start) begin
            state     <= START;
            busy      <= 1'b1;
            rom_addr  <= '0;
            byte_idx  <= '0;
            retry_cnt <= '0;
            ack_error <= 1'b0;
            phase     <= '0;
          end
        end
        START: if (tick) begin
          phase <= phase + 2'd1;
          case (phase)
            2'd0: begin i2c_sclk <= 1'b1; i2c_sdat_oe <= 1'b0; end
            2'd1: begin i2c_sclk <= 1'b1; i2c_sdat_oe <= 1'b1; end
            2'd2: begin i2c_sclk <= 1'b0; i2c_sdat_oe <= 1'b1; end
            2'd3: begin
              state       <= BIT;
              bit_cnt     <= '0;
              byte_idx    <= '0;
              shreg       <= ADDR_BYTE;
              i2c_sclk    <= 1'b0;
              i2c_sdat_oe <= ~ADDR_BYTE[7];
            end
          endcase
        end
        BIT: if (tick) begin
          phase <= phase + 2'd1;
          case (phase)
            2'd0, 2'd1: i2c_sclk <= 1'b1;
            2'd2:       i2c_sclk <= 1'b0;
            2'd3: begin
              if (bit_cnt == 3'd7) begin
                state       <= ACK;
                i2c_sdat_oe <= 1'b0;
              end else begin
                bit_cnt     <= bit_cnt + 3'd1;
                shreg       <= {shreg[6:0], 1'b0};
                i2c_sdat_oe <= ~shreg[6];
              end
            end
          endcase
        end
        ACK: if (tick) begin
          phase <= phase + 2'd1;
          case (phase)
            2'd0, 2'd1: i2c_sclk <= 1'b1;
            2'd2: begin
              i2c_sclk <= 1'b0;
              nacked   <= i2c_sdat_in;
            end
            2'd3: begin
              if (nacked) begin
                state       <= STOP;
                retry_cnt   <= retry_cnt + 8'd1;
                i2c_sdat_oe <= 1'b1;
              end else if (byte_idx != 2'd2) begin
                state       <= BIT;
                byte_idx    <= byte_idx + 2'd1;
                bit_cnt     <= '0;
                shreg       <= next_byte;
                i2c_sdat_oe <= ~next_byte[7];
              end else begin
                state       <= STOP;
                i2c_sdat_oe <= 1'b1;
              end
            end
          endcase
        end
        STOP: if (tick) begin
          phase <= phase + 2'd1;
          case (phase)
            2'd0: i2c_sclk    <= 1'b1;
            2'd1: i2c_sdat_oe <= 1'b0;
            2'd2: ;
            2'd3: state       <= NEXT;
          endcase
        end
        NEXT: begin
          phase    <= '0;
          byte_idx <= '0;
          if (nacked) begin
            if (retry_cnt <= RETRY_LIMIT) begin
              state <= START;
            end else begin
              ack_error <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end
          end else if (rom_addr == LAST_ADDR) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            rom_addr  <= rom_addr + 6'd1;
            retry_cnt <= '0;
            state     <= START;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_av_config_sequencer.sv
// Bench for av_config_sequencer: an I2C slave/decoder turns the bus into tokens
// that a monitor checks against a queue of expected tokens filled by the stimulus.
module tb_av_config_sequencer;

  localparam int TOK_START = 'h101;
  localparam int TOK_STOP  = 'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  rom_addr;
  logic [15:0] rom_data;
  logic        i2c_sclk, i2c_sdat_oe, i2c_sdat_in;
  logic        busy, done, ack_error;
  logic        slave_low = 1'b0;
  logic [15:0] rom [0:1] = '{16'h1E00, 16'h0C10};

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int busy_cycles = 0;
  int done_cnt = 0;
  int ack_mode = 0;
  logic nack_pending = 1'b0;
  logic hit5 = 1'b0;

  logic       prev_scl = 1'b1, prev_sda = 1'b1, dec_scl, dec_sda;
  logic       in_frame = 1'b0, ack_slot = 1'b0, ack_clk = 1'b0;
  logic [7:0] sh = '0;
  int         bitcnt = 0;
  int         byte_in_frame = 0;

  assign rom_data    = (rom_addr < 6'd2) ? rom[rom_addr[0]] : 16'h0000;
  assign i2c_sdat_in = ~(i2c_sdat_oe | slave_low);

  always #5 clk = ~clk;

  av_config_sequencer #(
    .CLK_DIV(4),
    .NUM_WORDS(2),
    .DEV_ADDR(7'h1A),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .i2c_sclk(i2c_sclk),
    .i2c_sdat_oe(i2c_sdat_oe),
    .i2c_sdat_in(i2c_sdat_in),
    .busy(busy),
    .done(done),
    .ack_error(ack_error)
  );

  task automatic check(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, want, want);
    end
  endtask

  task automatic observe(input int tok);
    int want;
    if (exp_q.size() == 0) begin
      check("unexpected_bus_token", tok, -1);
    end else begin
      want = exp_q.pop_front();
      check("bus_token", tok, want);
    end
  endtask

  // Slave + decoder + protocol checker, evaluated away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      dec_scl = i2c_sclk;
      dec_sda = i2c_sdat_in;
      if (reset) begin
        bitcnt = 0; in_frame = 1'b0; ack_slot = 1'b0; ack_clk = 1'b0;
        slave_low = 1'b0; byte_in_frame = 0;
      end else begin
        if (dec_sda != prev_sda) begin
          if (dec_scl && prev_scl) begin
            if (!dec_sda) begin
              check("start_outside_frame", int'(in_frame), 0);
              observe(TOK_START);
              in_frame = 1'b1; bitcnt = 0; byte_in_frame = 0;
            end else begin
              check("stop_after_ack_slot",
                    int'(in_frame && !ack_slot && bitcnt == 1 && !sh[0]), 1);
              observe(TOK_STOP);
              in_frame = 1'b0; bitcnt = 0;
            end
          end else begin
            check("sda_change_while_scl_high", int'(dec_scl | prev_scl), 0);
          end
        end
        if (dec_scl && !prev_scl) begin
          if (ack_slot) begin
            check("ack_slot_oe", int'(i2c_sdat_oe), 0);
            ack_clk = 1'b1;
          end else if (bitcnt < 8) begin
            sh = {sh[6:0], dec_sda};
            bitcnt++;
            if (in_frame && byte_in_frame == 1 && bitcnt == 5) hit5 = 1'b1;
            if (bitcnt == 8) observe(int'(sh));
          end
        end
        if (!dec_scl && prev_scl) begin
          if (ack_slot && ack_clk) begin
            ack_slot = 1'b0; ack_clk = 1'b0; slave_low = 1'b0;
            bitcnt = 0; byte_in_frame++;
          end else if (bitcnt == 8 && !ack_slot) begin
            ack_slot = 1'b1;
            if (ack_mode == 2) slave_low = (byte_in_frame != 0);
            else if (ack_mode == 1 && byte_in_frame == 1 && nack_pending) begin
              slave_low = 1'b0;
              nack_pending = 1'b0;
            end else slave_low = 1'b1;
          end
        end
      end
      prev_scl = dec_scl;
      prev_sda = i2c_sdat_in;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic push_word(input logic [15:0] w);
    exp_q.push_back(TOK_START);
    exp_q.push_back('h34);
    exp_q.push_back(int'(w[15:8]));
    exp_q.push_back(int'(w[7:0]));
    exp_q.push_back(TOK_STOP);
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic begin_walk();
    busy_cycles = 0;
    done_cnt = 0;
    pulse_start();
    check("busy_after_start", int'(busy), 1);
    check("ack_error_cleared_by_start", int'(ack_error), 0);
  endtask

  task automatic finish_walk(input int want_busy, input int want_err);
    int n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk); #1;
      n++;
    end
    check("done_seen_before_timeout", int'(done_cnt != 0), 1);
    repeat (4) @(negedge clk);
    #1;
    check("busy_cycle_count", busy_cycles, want_busy);
    check("done_pulse_count", done_cnt, 1);
    check("ack_error_final", int'(ack_error), want_err);
    check("busy_low_after_done", int'(busy), 0);
    check("expected_tokens_left", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    check("reset_sclk", int'(i2c_sclk), 1);
    check("reset_oe", int'(i2c_sdat_oe), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_ack_error", int'(ack_error), 0);
    check("reset_rom_addr", int'(rom_addr), 0);

    // Clean two-word walk
    ack_mode = 0;
    push_word(16'h1E00);
    push_word(16'h0C10);
    begin_walk();
    finish_walk(931, 0);

    // One NACK on the second byte of word 0, then ACKs
    ack_mode = 1;
    nack_pending = 1'b1;
    exp_q.push_back(TOK_START); exp_q.push_back('h34);
    exp_q.push_back('h1E);      exp_q.push_back(TOK_STOP);
    push_word(16'h1E00);
    push_word(16'h0C10);
    begin_walk();
    finish_walk(1252, 0);

    // Every address byte NACKed: 1 + MAX_RETRY attempts, then abort
    ack_mode = 2;
    repeat (4) begin
      exp_q.push_back(TOK_START); exp_q.push_back('h34); exp_q.push_back(TOK_STOP);
    end
    begin_walk();
    finish_walk(709, 1);
    check("rom_addr_after_abort", int'(rom_addr), 0);

    // Recovery walk after abort clears ack_error
    ack_mode = 0;
    push_word(16'h1E00);
    push_word(16'h0C10);
    begin_walk();
    finish_walk(931, 0);

    // Second start during word 1 is ignored
    push_word(16'h1E00);
    push_word(16'h0C10);
    begin_walk();
    n = 0;
    while (rom_addr != 6'd1 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check("reached_word1_before_timeout", int'(rom_addr == 6'd1), 1);
    repeat (40) @(negedge clk);
    pulse_start();
    finish_walk(931, 0);

    // Reset at the 5th bit of the second byte
    hit5 = 1'b0;
    exp_q.push_back(TOK_START);
    exp_q.push_back('h34);
    begin_walk();
    n = 0;
    while (!hit5 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check("bit5_reached_before_timeout", int'(hit5), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_sclk", int'(i2c_sclk), 1);
    check("midreset_oe", int'(i2c_sdat_oe), 0);
    check("midreset_busy", int'(busy), 0);
    @(negedge clk); #1 reset = 1'b0;
    check("midreset_tokens_left", exp_q.size(), 0);
    push_word(16'h1E00);
    push_word(16'h0C10);
    begin_walk();
    finish_walk(931, 0);

    // Reset wins over a simultaneous start
    busy_cycles = 0;
    done_cnt = 0;
    @(negedge clk); #1 begin reset = 1'b1; start = 1'b1; end
    @(posedge clk); #1;
    check("reset_vs_start_busy", int'(busy), 0);
    @(negedge clk); #1 begin reset = 1'b0; start = 1'b0; end
    repeat (20) @(negedge clk);
    #1;
    check("reset_vs_start_stays_idle", busy_cycles, 0);
    check("reset_vs_start_no_done", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/av_config_sequencer.md
AV_CONFIG_SEQUENCER -- requirements
Module: av_config_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CLK_DIV, 250, clk cycles per quarter-bit tick; default gives 100 kHz SCL from 100 MHz; legal range 2..1023.
- NUM_WORDS, 11, number of 16-bit configuration words in the table; range 1..64.
- DEV_ADDR, 7'h1A, 7-bit I2C slave address; the first byte sent is {DEV_ADDR, 1'b0} = 8'h34.
- MAX_RETRY, 3, re-attempts of one word after a NACK before the block aborts.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic is on its rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle pulse that begins a full table walk.
- rom_addr, out, 6, index of the current table word.
- rom_data, in, 16, table word at rom_addr, valid combinationally; [15:8] is byte 1, [7:0] is byte 2.
- i2c_sclk, out, 1, SCL level; push-pull.
- i2c_sdat_oe, out, 1, 1 = drive SDA low, 0 = release SDA (pulled high externally).
- i2c_sdat_in, in, 1, sampled SDA level; the top level synchronizes this input.
- busy, out, 1, high from the cycle after an accepted start until completion.
- done, out, 1, one-cycle pulse when the walk ends, on success or on abort.
- ack_error, out, 1, sticky; set on abort; cleared by the next accepted start.

Function
REQ-003 The tick counter shall count 0..CLK_DIV-1 only while busy and emit tick on terminal count; it shall be held at 0 when idle.
REQ-004 The FSM states shall be IDLE, START, BIT, ACK, STOP, NEXT, DONE; all transitions except IDLE->START and NEXT/DONE occur on tick only.
REQ-005 IDLE: SCL=1, oe=0, busy=0; start=1 moves the FSM to START, sets rom_addr=0, byte index=0, retry count=0, and clears ack_error.
REQ-006 The block shall ignore start while busy=1.
REQ-007 START takes 4 ticks: phases 0-1 SCL=1/oe=0; phase 2 SCL=1/oe=1 (START condition); phase 3 SCL=0/oe=1.
REQ-008 BIT takes 4 ticks per bit, MSB first: phase 0 SCL=0, set oe=~bit; phases 1-2 SCL=1; phase 3 SCL=0. After 8 bits the FSM goes to ACK.
REQ-009 Byte order per word: {DEV_ADDR,0}, rom_data[15:8], rom_data[7:0].
REQ-010 ACK has the same 4 phases as BIT with oe=0; i2c_sdat_in is sampled at the end of phase 2; 0 = ACK, 1 = NACK.
REQ-011 ACK followed by byte index <2: the index increments and the FSM returns to BIT; after the third byte the FSM goes to STOP.
REQ-012 NACK on any byte: the FSM goes directly to STOP and the retry count increments.
REQ-013 STOP takes 4 ticks: phase 0 SCL=0/oe=1; phase 1 SCL=1/oe=1; phases 2-3 SCL=1/oe=0 (STOP condition and bus-free time).
REQ-014 NEXT is a single clk cycle, not tick-gated:
- after a NACK with retry count <= MAX_RETRY: repeat the same rom_addr;
- after a NACK with retry count > MAX_RETRY: set ack_error and go to DONE;
- after success with rom_addr = NUM_WORDS-1: go to DONE;
- after any other success: increment rom_addr, reset retry count to 0, and return to START.
REQ-015 DONE is one cycle: done=1, busy drops the following cycle, then IDLE.
REQ-016 A successful word takes exactly 116 ticks (4 + 27x4 + 4) plus 1 cycle in NEXT.
REQ-017 rom_addr shall be stable for an entire word attempt, START through STOP.

Reset
REQ-018 When reset=1 at a clock edge, the next state shall be: FSM=IDLE, SCL=1, oe=0, busy=0, done=0, ack_error=0, rom_addr=0, tick counter=0, retry count=0.
REQ-019 Reset mid-transfer shall release the bus the next cycle with no STOP generated; the following start restarts from word 0.
REQ-020 Reset shall take priority over a start asserted in the same cycle.

Verification
REQ-021 Bench parameters: CLK_DIV=4, NUM_WORDS=2. rom[0]=16'h1E00, rom[1]=16'h0C10, and the slave model always ACKs.
- Pulse start. Required: decoded bytes 34,1E,00 then 34,0C,10; busy high for 2x(464+1)+1 cycles; one done pulse; ack_error=0.
REQ-022 Slave NACKs the second byte of word 0 once, then ACKs.
- Required: STOP immediately after that ACK slot; word 0 resent in full; walk completes; ack_error=0.
REQ-023 Slave NACKs every address byte.
- Required: exactly 4 attempts of word 0 (1 + MAX_RETRY); done pulse; ack_error=1; rom_addr=0.
- Then a start with an ACKing slave: ack_error clears in the cycle after start.
REQ-024 Start pulsed again during word 1.
- Required: no effect on the bus sequence and a single done pulse.
REQ-025 Reset asserted at the 5th bit of byte 2.
- Required: the next cycle shows SCL=1, oe=0, busy=0.
- A following start produces the full sequence from rom_addr=0.
REQ-026 Protocol checker throughout all scenarios:
- SDA changes only while SCL=0, except at START and STOP;
- i2c_sdat_oe=0 in every ACK slot.
